// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Main control FSM for a multicycle MIPS-subset datapath
//               (lw, sw, R-type, beq, j, addi). Moore strobes per state,
//               with IRWrite/PCWrite in FETCH gated by mem_ready. Also
//               flags unsupported opcodes and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  ALUop,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [15:0] instr_count
);

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation and operand-select encodings
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;
    localparam logic [1:0] PCS_ALU   = 2'b00;
    localparam logic [1:0] PCS_OUT   = 2'b01;
    localparam logic [1:0] PCS_JUMP  = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   decode_illegal;   // DECODE sees an opcode outside the supported set
    logic   retire;           // the current edge completes an instruction

    assign state = cur_state;

    // State register; reset parks the machine in FETCH so FETCH strobes show during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and Moore output decode; every strobe defaults to 0
    always_comb begin
        nxt_state      = FETCH;
        decode_illegal = 1'b0;
        retire         = 1'b0;
        PCWrite        = 1'b0;
        PCWriteCond    = 1'b0;
        IorD           = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        IRWrite        = 1'b0;
        MemtoReg       = 1'b0;
        RegWrite       = 1'b0;
        RegDst         = 1'b0;
        ALUSrcA        = 1'b0;
        ALUop          = ALU_ADD;
        ALUSrcB        = SRCB_REG;
        PCSource       = PCS_ALU;

        case (cur_state)
            FETCH: begin
                // PC+4 is written back and the IR loaded only when the read returns
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                nxt_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Branch target is precomputed here from PC + (imm << 2)
                ALUSrcB = SRCB_IMM4;
                case (opcode)
                    OP_RTYPE:     nxt_state = EXEC;
                    OP_LW, OP_SW: nxt_state = MEMADR;
                    OP_BEQ:       nxt_state = BRANCH;
                    OP_J:         nxt_state = JUMP;
                    OP_ADDI:      nxt_state = ADDIEX;
                    default: begin
                        nxt_state      = FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nxt_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                retire    = mem_ready;
                nxt_state = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_REG;
                ALUop     = ALU_FUNCT;
                nxt_state = ALUWB;
            end
            ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            BRANCH: begin
                // Subtract for the zero test; PC takes the target held in ALUOut
                ALUSrcA     = 1'b1;
                ALUop       = ALU_SUB;
                PCSource    = PCS_OUT;
                PCWriteCond = 1'b1;
                retire      = 1'b1;
                nxt_state   = FETCH;
            end
            JUMP: begin
                PCSource  = PCS_JUMP;
                PCWrite   = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            ADDIEX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                nxt_state = ADDIWB;
            end
            ADDIWB: begin
                // rt destination, ALU result source: RegDst/MemtoReg stay 0
                RegWrite  = 1'b1;
                retire    = 1'b1;
                nxt_state = FETCH;
            end
            default: begin
                // Unused encodings 12-15 recover to FETCH
                nxt_state = FETCH;
            end
        endcase
    end

    // Illegal-opcode pulse lands in the cycle the machine returns to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= decode_illegal;
        end
    end

    // Retired-instruction counter, free-running wrap at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= 16'h0000;
        end else if (retire) begin
            instr_count <= instr_count + 16'h0001;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Directed, table-driven bench for mc_control_fsm plus hand
//               sequences for reset, async abort and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0]  ALUop, ALUSrcB, PCSource;
    logic [3:0]  state;
    logic        illegal_op;
    logic [15:0] instr_count;

    mc_control_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUop       (ALUop),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .state       (state),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    //               MemtoReg,RegWrite,RegDst,ALUSrcA,ALUop,ALUSrcB,PCSource}
    localparam logic [15:0] C_FETCH1 = 16'h9404;
    localparam logic [15:0] C_FETCH0 = 16'h1004;
    localparam logic [15:0] C_DECODE = 16'h000C;
    localparam logic [15:0] C_MEMADR = 16'h0048;
    localparam logic [15:0] C_MEMRD  = 16'h3000;
    localparam logic [15:0] C_MEMWB  = 16'h0300;
    localparam logic [15:0] C_MEMWR  = 16'h2800;
    localparam logic [15:0] C_EXEC   = 16'h0060;
    localparam logic [15:0] C_ALUWB  = 16'h0180;
    localparam logic [15:0] C_BRANCH = 16'h4051;
    localparam logic [15:0] C_JUMP   = 16'h8002;
    localparam logic [15:0] C_ADDIEX = 16'h0048;
    localparam logic [15:0] C_ADDIWB = 16'h0100;

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   applied;
    int   miscompares;
    logic [15:0] got_ctrl;

    assign got_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegWrite, RegDst, ALUSrcA, ALUop, ALUSrcB, PCSource};

    task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                       input logic [15:0] ctrl, input logic ill, input logic [15:0] cnt);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctrl = ctrl; v.ill = ill; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] st, input logic [15:0] ctrl,
                         input logic ill, input logic [15:0] cnt);
        applied++;
        if (state !== st || got_ctrl !== ctrl || illegal_op !== ill || instr_count !== cnt) begin
            miscompares++;
            $display("FAIL %s: got state=%0d ctrl=%h ill=%b cnt=%h, expected state=%0d ctrl=%h ill=%b cnt=%h",
                     name, state, got_ctrl, illegal_op, instr_count, st, ctrl, ill, cnt);
        end
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        opcode      = 6'b100011;
        mem_ready   = 1'b1;

        // lw, mem_ready=1: 0,1,2,3,4 then retire
        add(6'h23,1,0,C_FETCH1,0,0); add(6'h23,1,1,C_DECODE,0,0); add(6'h23,1,2,C_MEMADR,0,0);
        add(6'h23,1,3,C_MEMRD ,0,0); add(6'h23,1,4,C_MEMWB ,0,0);
        // sw with three wait cycles in MEMWR
        add(6'h2B,1,0,C_FETCH1,0,1); add(6'h2B,1,1,C_DECODE,0,1); add(6'h2B,1,2,C_MEMADR,0,1);
        add(6'h2B,0,5,C_MEMWR ,0,1); add(6'h2B,0,5,C_MEMWR ,0,1); add(6'h2B,0,5,C_MEMWR ,0,1);
        add(6'h2B,1,5,C_MEMWR ,0,1);
        // R-type, with one FETCH wait
        add(6'h00,0,0,C_FETCH0,0,2); add(6'h00,1,0,C_FETCH1,0,2); add(6'h00,1,1,C_DECODE,0,2);
        add(6'h00,1,6,C_EXEC  ,0,2); add(6'h00,1,7,C_ALUWB ,0,2);
        // beq
        add(6'h04,1,0,C_FETCH1,0,3); add(6'h04,1,1,C_DECODE,0,3); add(6'h04,1,8,C_BRANCH,0,3);
        // illegal opcode: pulse coincides with the return to FETCH, no count
        add(6'h3F,1,0,C_FETCH1,0,4); add(6'h3F,1,1,C_DECODE,0,4);
        // addi (its FETCH carries the illegal pulse)
        add(6'h08,1,0,C_FETCH1,1,4); add(6'h08,1,1,C_DECODE,0,4); add(6'h08,1,10,C_ADDIEX,0,4);
        add(6'h08,1,11,C_ADDIWB,0,4);
        // j
        add(6'h02,1,0,C_FETCH1,0,5); add(6'h02,1,1,C_DECODE,0,5); add(6'h02,1,9,C_JUMP,0,5);
        // lw with one wait in MEMRD
        add(6'h23,1,0,C_FETCH1,0,6); add(6'h23,1,1,C_DECODE,0,6); add(6'h23,1,2,C_MEMADR,0,6);
        add(6'h23,0,3,C_MEMRD ,0,6); add(6'h23,1,3,C_MEMRD ,0,6); add(6'h23,1,4,C_MEMWB ,0,6);

        // Reset holds FETCH with its strobes visible, across clock edges
        repeat (2) @(negedge clk);
        mem_ready = 1'b1; #1;
        check("reset_mr1", 4'd0, C_FETCH1, 1'b0, 16'h0000);
        @(negedge clk);
        mem_ready = 1'b0; #1;
        check("reset_mr0", 4'd0, C_FETCH0, 1'b0, 16'h0000);

        // Table: release reset and apply one vector per cycle
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            opcode    = vecs[i].op;
            mem_ready = vecs[i].mr;
            #1;
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].ill, vecs[i].cnt);
        end

        // Async reset in the middle of a MEMRD wait aborts without counting
        @(negedge clk);
        opcode = 6'h23; mem_ready = 1'b1; #1;
        check("pre_abort_fetch", 4'd0, C_FETCH1, 1'b0, 16'h0007);
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0; #1;
        check("in_memrd", 4'd3, C_MEMRD, 1'b0, 16'h0007);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_abort", 4'd0, C_FETCH0, 1'b0, 16'h0000);

        // Counter wrap: 65535 jumps to reach 0xFFFF, then one more
        @(negedge clk);
        opcode = 6'h02; mem_ready = 1'b1;
        rst_n  = 1'b1;
        repeat (3 * 65535) @(posedge clk);
        @(negedge clk); #1;
        check("count_ffff", 4'd0, C_FETCH1, 1'b0, 16'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("count_wrap", 4'd0, C_FETCH1, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
